// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter and byte/half read-modify-write sequencer for dm_1k
module dm_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic              p0_err,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              p1_err,
  output logic [31:0]       p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  input  logic [31:0]       mem_dout
);
  typedef enum logic [2:0] {IDLE, ACC, RMW_RD, RMW_WR, ERR} state_t;
  state_t r_state, w_next;
  logic r_last, r_id, r_we;
  logic [1:0] r_size, r_done, r_err, w_size;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [31:0] r_wdata, r_merge, r_rdata0, r_rdata1, w_wdata, w_mask, w_load;
  logic [ADDR_W:0] w_end;
  logic w_g0, w_g1, w_we, w_oob, w_fin, w_upd;
  assign w_g0 = r_state == IDLE && p0_req && (!p1_req || r_last);
  assign w_g1 = r_state == IDLE && p1_req && (!p0_req || !r_last);
  assign w_we = w_g1 ? p1_we : p0_we;
  assign w_size = w_g1 ? p1_size : p0_size;
  assign w_addr = w_g1 ? p1_addr : p0_addr;
  assign w_wdata = w_g1 ? p1_wdata : p0_wdata;
  assign w_end = {1'b0, w_addr} + (ADDR_W+1)'(w_size[1] ? 4 : w_size[0] ? 2 : 1);
  assign w_oob = w_end > (ADDR_W+1)'(MEM_BYTES);
  assign w_mask = r_size[1] ? 32'hffff_ffff : r_size[0] ? 32'h0000_ffff : 32'h0000_00ff;
  assign w_fin = r_state == ACC || r_state == RMW_WR || r_state == ERR;
  assign w_upd = (r_state == ACC && !r_we) || r_state == ERR;
  assign w_load = r_state == ERR ? '0 : mem_dout & w_mask;
  assign p0_done = r_done[0];
  assign p1_done = r_done[1];
  assign p0_err = r_err[0];
  assign p1_err = r_err[1];
  assign p0_rdata = r_rdata0;
  assign p1_rdata = r_rdata1;
  // state register; reset drops any in-flight access
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // next state: IDLE dispatches the granted access, RMW_RD chains into RMW_WR, all else returns to IDLE
  always_comb
    w_next = r_state == RMW_RD ? RMW_WR :
             r_state != IDLE ? IDLE :
             !(w_g0 || w_g1) ? IDLE :
             w_oob ? ERR :
             (!w_we || w_size[1]) ? ACC : RMW_RD;
  // grants and memory-side drive; the write merge keeps the upper bytes read back in RMW_RD
  always_comb begin
    p0_gnt = w_g0;
    p1_gnt = w_g1;
    mem_addr = (r_state == ACC || r_state == RMW_RD || r_state == RMW_WR) ? r_addr : '0;
    mem_we = (r_state == ACC && r_we) || r_state == RMW_WR;
    mem_din = r_state == RMW_WR ? (r_merge & ~w_mask) | (r_wdata & w_mask) :
              (r_state == ACC && r_we) ? r_wdata : '0;
  end
  // request latch, merge capture, registered completion pulses and per-port read data
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_last <= 1'b1;
      r_id <= 1'b0;
      r_we <= 1'b0;
      r_size <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_merge <= '0;
      r_done <= '0;
      r_err <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_g0 || w_g1) begin
        r_last <= w_g1;
        r_id <= w_g1;
        r_we <= w_we;
        r_size <= w_size;
        r_addr <= w_addr;
        r_wdata <= w_wdata;
      end
      if (r_state == RMW_RD) r_merge <= mem_dout;
      r_done <= w_fin ? (r_id ? 2'b10 : 2'b01) : 2'b00;
      r_err <= r_state == ERR ? (r_id ? 2'b10 : 2'b01) : 2'b00;
      if (w_upd && !r_id) r_rdata0 <= w_load;
      if (w_upd && r_id) r_rdata1 <= w_load;
    end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-requester arbiter and access sequencer for the 1 KB byte-addressed, little-endian data memory dm_1k. Memory word access at byte address A covers bytes A..A+3, with byte A in bits [7:0].
The block grants one requester at a time with round-robin priority. It drives the memory's addr/din/WriteEn, and converts byte and halfword stores into a read-modify-write pair.
It sits between the CPU load/store unit (port 0) and a secondary master such as a debug or DMA engine (port 1).

Parameters:
ADDR_W, 10, memory byte-address width.
MEM_BYTES, 1024, memory size in bytes; used for bounds checks.

Ports:
clk  in  1  clock; all state changes on posedge.
rst_n  in  1  synchronous active-low reset.
p0_req  in  1  port 0 access request.
p0_we  in  1  port 0: 1 = store, 0 = load.
p0_size  in  2  port 0 size: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
p0_addr  in  ADDR_W  port 0 byte address.
p0_wdata  in  32  port 0 store data, right-aligned.
p0_gnt  out  1  port 0 request accepted this cycle (combinational).
p0_done  out  1  one-cycle completion pulse for port 0.
p0_err  out  1  valid with p0_done: access out of bounds.
p0_rdata  out  32  port 0 load data, zero-extended, valid with p0_done.
p1_*  (same set as p0_*)  port 1 equivalents.
mem_addr  out  ADDR_W  to dm_1k addr.
mem_din  out  32  to dm_1k din.
mem_we  out  1  to dm_1k WriteEn.
mem_dout  in  32  from dm_1k dout; combinational read of mem_addr.

Behaviour:
- Reset (rst_n sampled low at posedge):
  - state=IDLE; last-served pointer=1, so port 0 wins the first tie.
  - all done/err=0; rdata=0; mem_we=0; mem_addr=0; mem_din=0.
  - Takes effect regardless of state; an in-flight access is dropped with no done and no further write.
- States: IDLE, ACC, RMW_RD, RMW_WR, ERR.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port not last served.
  - gnt is combinational, asserted only in IDLE.
  - At the granting edge, latch port id, we, size, addr and wdata; update the pointer.
  - Requester may drop req after gnt and must not re-request before its done.
- Bounds: nbytes = 1/2/4 by size. If addr+nbytes > MEM_BYTES, go to ERR instead of memory access.
- Transitions:
  - Load → ACC.
  - Word store → ACC.
  - Byte/half store → RMW_RD.
  - Out of bounds → ERR.
- ACC: mem_addr = latched addr.
  - Store: mem_din = wdata, mem_we = 1.
  - Load: capture mem_dout masked to nbytes (zero-extended) into the port rdata register.
  - Next state IDLE.
- RMW_RD: mem_addr = addr, mem_we = 0. Capture mem_dout into the merge register. Next state RMW_WR.
- RMW_WR: mem_we = 1; mem_din = merge with low nbytes replaced by wdata low nbytes. Next state IDLE.
- ERR: no memory activity. rdata is set to 0 and err is flagged. Next state IDLE.
- done timing: done/err are registered. They pulse for one cycle in the cycle after the final state (ACC, RMW_WR or ERR), with the block back in IDLE.
- IDLE may grant a new request in that same cycle, so back-to-back accesses are allowed.
- Latency from gnt cycle N:
  - done at N+2 for loads, word stores and errors.
  - done at N+3 for byte/half stores.
- rdata holds its last value until the next done on that port. Stores leave rdata unchanged.
- mem_addr/mem_din are 0 in IDLE and ERR; mem_we is high only in ACC-store and RMW_WR.
- A request arriving while the block is busy waits (no gnt) until IDLE. There is no starvation: under continuous contention, grants alternate.

Test Plan:
- Reset, then port 0 word store 0x12345678 @0; port 0 load word @1.
  → gnt at N, done at N+2, p0_rdata=0x00123456, err=0.
- Byte store 0xAB @2 over 0x12345678 @0; load word @0.
  → done at N+3 for the store; read 0x12AB5678. Exactly one mem_we cycle; bytes @3..5 unchanged.
- Both ports request loads continuously for 6 grants from reset.
  → grant order 0,1,0,1,0,1; each port sees 3 dones; never both gnt in one cycle.
- Port 1 word load @1021, and half store @1023.
  → done with err=1, rdata=0, mem_we never high. Word @1020 and half @1022 succeed with err=0.
- rst_n low for one edge while in RMW_RD of a half store @8.
  → next cycle IDLE, mem_we=0, no done. Memory @8..11 unchanged; a fresh tie goes to port 0.
